reel_stop_scheduler: RTL and testbench

- Sequencing controller for the seven-reel selecting machine.
- Replaces the free-running per-reel divided clocks with single-clock tick enables.
- Enforces the stop order reel 6 → reel 0; a reel's stop request is honoured only after the previous reel has stopped.
- Each stop is aligned to that reel's next tick, so the displayed symbol never changes after `run` drops.
- An auto-stop timeout stops the pending reel if the player does nothing.

---
 rtl/sel_pkg.sv | 21 ++
 rtl/tick_gen.sv | 33 +++
 rtl/reel_stop_scheduler.sv | 123 ++++++++++++
 tb/tb_reel_stop_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sel_pkg.sv
// Shared types and default parameters for the seven-reel stop scheduler.
package sel_pkg;

    localparam int unsigned NUM_REELS = 7;
    localparam int unsigned CNT_W     = 28;
    localparam int unsigned TIMEOUT   = 250000000;

    // Field i is the tick period of reel i; reel 6 occupies the MSB field.
    localparam logic [NUM_REELS*CNT_W-1:0] DIV_TABLE = {
        28'd12500000, 28'd10000000, 28'd7500000, 28'd5000000,
        28'd2500000,  28'd2000000,  28'd1250000
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPIN   = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/tick_gen.sv
// Per-reel tick enable: one registered pulse every DIV cycles while en is high.
module tick_gen #(
    parameter int unsigned        CNT_W = 28,
    parameter logic [CNT_W-1:0]   DIV   = CNT_W'(2)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap = (r_cnt == DIV - CNT_W'(1));
    assign tick   = r_tick;

    // Counter is held at zero while the reel is stopped so a restart is phase-clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (en) begin
            r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            r_tick <= w_wrap;
        end else begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/reel_stop_scheduler.sv
// Stop sequencer for the reel machine: stops reels from the top index down,
// each stop aligned to that reel's next tick, with an auto-stop timeout.
module reel_stop_scheduler #(
    parameter int unsigned                  NUM_REELS = sel_pkg::NUM_REELS,
    parameter int unsigned                  CNT_W     = sel_pkg::CNT_W,
    parameter logic [NUM_REELS*CNT_W-1:0]   DIV_TABLE = sel_pkg::DIV_TABLE,
    parameter int unsigned                  TIMEOUT   = sel_pkg::TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_REELS-1:0] stop_pulse,
    output logic [NUM_REELS-1:0] run,
    output logic [NUM_REELS-1:0] tick,
    output logic [2:0]           next_reel,
    output logic                 busy,
    output logic                 done
);
    import sel_pkg::*;

    localparam int unsigned      IDX_W = 3;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_REELS - 1);

    state_t               r_state,     w_state_nxt;
    logic [NUM_REELS-1:0] r_run,       w_run_nxt;
    logic [IDX_W-1:0]     r_next_reel, w_next_reel_nxt;
    logic                 r_busy,      w_busy_nxt;
    logic                 r_done,      w_done_nxt;
    logic [CNT_W-1:0]     r_tmo,       w_tmo_nxt;
    logic [NUM_REELS-1:0] w_tick;
    logic                 w_timeout;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REELS; gi++) begin : g_reel
            tick_gen #(
                .CNT_W (CNT_W),
                .DIV   (DIV_TABLE[gi*CNT_W +: CNT_W])
            ) u_tick (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (r_run[gi]),
                .tick  (w_tick[gi])
            );
        end
    endgenerate

    assign w_timeout = (r_tmo == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_run       <= '0;
            r_next_reel <= LAST;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_tmo       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_run       <= w_run_nxt;
            r_next_reel <= w_next_reel_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_tmo       <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_run_nxt       = r_run;
        w_next_reel_nxt = r_next_reel;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_tmo_nxt       = r_tmo;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt     = SPIN;
                    w_run_nxt       = '1;
                    w_busy_nxt      = 1'b1;
                    w_tmo_nxt       = '0;
                    w_next_reel_nxt = LAST;
                end
            end
            SPIN: begin
                w_tmo_nxt = r_tmo + CNT_W'(1);
                if (stop_pulse[r_next_reel] || w_timeout) begin
                    w_state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                // The final tick still goes out; run drops on the edge that follows it.
                if (w_tick[r_next_reel]) begin
                    w_run_nxt[r_next_reel] = 1'b0;
                    if (r_next_reel == '0) begin
                        w_state_nxt     = DONE;
                        w_done_nxt      = 1'b1;
                        w_busy_nxt      = 1'b0;
                        w_next_reel_nxt = LAST;
                    end else begin
                        w_state_nxt     = SPIN;
                        w_next_reel_nxt = r_next_reel - IDX_W'(1);
                        w_tmo_nxt       = '0;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign run       = r_run;
    assign tick      = w_tick;
    assign next_reel = r_next_reel;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_reel_stop_scheduler.sv
// Bench for reel_stop_scheduler with short periods (DIV_i = i+3) and TIMEOUT = 40,
// compared every cycle against a timestamp-based reference model.
module tb_reel_stop_scheduler;

    localparam int unsigned NR  = 7;
    localparam int unsigned CW  = 28;
    localparam int          TMO = 40;
    localparam logic [NR*CW-1:0] DIVT = {28'd9, 28'd8, 28'd7, 28'd6, 28'd5, 28'd4, 28'd3};

    localparam int M_IDLE   = 0;
    localparam int M_SPIN   = 1;
    localparam int M_SETTLE = 2;
    localparam int M_DONE   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [NR-1:0] stop_pulse = '0;
    logic [NR-1:0] run;
    logic [NR-1:0] tick;
    logic [2:0]    next_reel;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    reel_stop_scheduler #(
        .NUM_REELS (NR),
        .CNT_W     (CW),
        .DIV_TABLE (DIVT),
        .TIMEOUT   (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop_pulse (stop_pulse),
        .run        (run),
        .tick       (tick),
        .next_reel  (next_reel),
        .busy       (busy),
        .done       (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: reel tick times follow from when each reel started spinning.
    int            c;
    int            m_mode;
    logic [NR-1:0] m_run;
    int            m_rise [NR];
    int            m_nr;
    logic          m_busy;
    int            m_wstart;

    function automatic int div_of(input int i);
        return i + 3;
    endfunction

    function automatic logic [NR-1:0] exp_ticks();
        logic [NR-1:0] t;
        for (int i = 0; i < NR; i++)
            t[i] = m_run[i] && (c > m_rise[i]) && (((c - m_rise[i]) % div_of(i)) == 0);
        return t;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE;
        m_run  = '0;
        m_busy = 1'b0;
        m_nr   = NR - 1;
        for (int i = 0; i < NR; i++) m_rise[i] = 0;
    endtask

    task automatic model_edge(input logic s, input logic [NR-1:0] sp);
        logic [NR-1:0] tk;
        tk = exp_ticks();
        case (m_mode)
            M_IDLE: if (s) begin
                m_mode = M_SPIN;
                m_run  = '1;
                for (int i = 0; i < NR; i++) m_rise[i] = c + 1;
                m_busy   = 1'b1;
                m_nr     = NR - 1;
                m_wstart = c + 1;
            end
            M_SPIN: if (sp[m_nr] || (c - m_wstart == TMO - 1)) m_mode = M_SETTLE;
            M_SETTLE: if (tk[m_nr]) begin
                m_run[m_nr] = 1'b0;
                if (m_nr == 0) begin
                    m_mode = M_DONE;
                    m_busy = 1'b0;
                    m_nr   = NR - 1;
                end else begin
                    m_nr     = m_nr - 1;
                    m_mode   = M_SPIN;
                    m_wstart = c + 1;
                end
            end
            default: m_mode = M_IDLE;
        endcase
        c++;
    endtask

    task automatic check_outputs();
        logic [NR-1:0] et;
        logic          ed;
        et = exp_ticks();
        ed = (m_mode == M_DONE);
        n_checks++;
        assert (run === m_run) else begin
            n_fail++; $error("FAIL run observed=%h expected=%h at cycle %0d", run, m_run, c);
        end
        n_checks++;
        assert (tick === et) else begin
            n_fail++; $error("FAIL tick observed=%h expected=%h at cycle %0d", tick, et, c);
        end
        n_checks++;
        assert (next_reel === 3'(m_nr)) else begin
            n_fail++; $error("FAIL next_reel observed=%0d expected=%0d at cycle %0d", next_reel, m_nr, c);
        end
        n_checks++;
        assert (busy === m_busy) else begin
            n_fail++; $error("FAIL busy observed=%b expected=%b at cycle %0d", busy, m_busy, c);
        end
        n_checks++;
        assert (done === ed) else begin
            n_fail++; $error("FAIL done observed=%b expected=%b at cycle %0d", done, ed, c);
        end
    endtask

    task automatic cyc(input logic s, input logic [NR-1:0] sp);
        start      = s;
        stop_pulse = sp;
        model_edge(s, sp);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        c++;
        check_outputs();
    endtask

    int            k;
    bit            ok;
    logic [NR-1:0] sp;

    initial begin
        c = 0;
        model_reset();

        // Power-on reset
        rst_n = 1'b0;
        repeat (3) reset_cycle();
        rst_n = 1'b1;
        cyc(1'b0, '0);
        cyc(1'b0, 7'h7F);   // stop requests in IDLE are ignored
        cyc(1'b0, '0);

        // Normal spin: run rises one cycle after start, reel 0 ticks at T+4
        cyc(1'b1, '0);
        n_checks++;
        assert (run === 7'h7F) else begin
            n_fail++; $error("FAIL run_after_start observed=%h expected=7f", run);
        end
        cyc(1'b1, '0);      // start while busy is ignored
        cyc(1'b0, '0);
        n_checks++;
        assert (tick[0] === 1'b0) else begin
            n_fail++; $error("FAIL tick0_early observed=%b expected=0", tick[0]);
        end
        cyc(1'b0, '0);
        n_checks++;
        assert (tick[0] === 1'b1) else begin
            n_fail++; $error("FAIL tick0_first observed=%b expected=1", tick[0]);
        end

        // In-order stops at random moments until done
        ok = 1'b0;
        for (k = 0; k < 2000 && !ok; k++) begin
            sp = (m_mode == M_SPIN && ($urandom % 6) == 0) ? 7'(1 << m_nr) : '0;
            cyc(1'b0, sp);
            if (m_mode == M_DONE) ok = 1'b1;
        end
        n_checks++;
        assert (ok && done === 1'b1 && run === '0) else begin
            n_fail++; $error("FAIL inorder_done observed done=%b run=%h expected done=1 run=00", done, run);
        end
        cyc(1'b1, '0);      // start during DONE is ignored
        n_checks++;
        assert (busy === 1'b0) else begin
            n_fail++; $error("FAIL start_in_done observed busy=%b expected=0", busy);
        end
        cyc(1'b0, '0);

        // Out-of-order requests, then all bits at once
        cyc(1'b1, '0);
        repeat (5) cyc(1'b0, 7'h08);
        n_checks++;
        assert (next_reel === 3'd6 && run === 7'h7F) else begin
            n_fail++; $error("FAIL out_of_order observed next_reel=%0d run=%h expected 6/7f", next_reel, run);
        end
        cyc(1'b0, 7'h7F);
        ok = 1'b0;
        for (k = 0; k < 100 && !ok; k++) begin
            cyc(1'b0, '0);
            if (m_nr == 5) ok = 1'b1;
        end
        n_checks++;
        assert (ok && run === 7'h3F) else begin
            n_fail++; $error("FAIL all_bits_stop observed run=%h expected=3f", run);
        end

        // Stop request on the same cycle as the pending reel's tick
        ok = 1'b0;
        for (k = 0; k < 100 && !ok; k++) begin
            if (exp_ticks() & 7'h20) ok = 1'b1;
            else cyc(1'b0, '0);
        end
        n_checks++;
        assert (ok && tick[5] === 1'b1) else begin
            n_fail++; $error("FAIL tick5_wait observed tick=%h expected bit5 set", tick);
        end
        cyc(1'b0, 7'h20);
        ok = 1'b0;
        for (k = 0; k < 100 && !ok; k++) begin
            cyc(1'b0, '0);
            if (m_nr == 4) ok = 1'b1;
        end
        n_checks++;
        assert (ok && next_reel === 3'd4) else begin
            n_fail++; $error("FAIL stop_on_tick observed next_reel=%0d expected=4", next_reel);
        end

        // Abort: asynchronous reset while reel 4 is settling
        cyc(1'b0, 7'h10);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_outputs();
        n_checks++;
        assert (run === '0 && busy === 1'b0 && next_reel === 3'd6) else begin
            n_fail++; $error("FAIL async_reset observed run=%h busy=%b next_reel=%0d expected 00/0/6", run, busy, next_reel);
        end
        reset_cycle();
        rst_n = 1'b1;
        repeat (12) cyc(1'b0, '0);

        // Full timeout run: no stop requests at all
        cyc(1'b1, '0);
        ok = 1'b0;
        for (k = 0; k < 1000 && !ok; k++) begin
            cyc(1'b0, '0);
            if (m_mode == M_DONE) ok = 1'b1;
        end
        n_checks++;
        assert (ok && done === 1'b1) else begin
            n_fail++; $error("FAIL timeout_done observed done=%b expected=1", done);
        end
        cyc(1'b0, '0);

        // Random traffic: starts, stop pulses with stray bits, timeouts
        repeat (1500) begin
            sp = (($urandom % 5) == 0) ? 7'($urandom) : '0;
            cyc((($urandom % 25) == 0), sp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
